// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU core: opcode map, jump-condition
// codes, FSM state and ALU operation encodings.
package cpu_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_JUMP   = 4'b1000;
    localparam logic [3:0] OP_JCOND  = 4'b1001;
    localparam logic [3:0] OP_INPUT  = 4'b1010;
    localparam logic [3:0] OP_OUTPUT = 4'b1110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    // Condition field sits in opcode bits [3:2] of the conditional jump
    localparam logic [1:0] JCC_Z  = 2'b00;
    localparam logic [1:0] JCC_NZ = 2'b01;
    localparam logic [1:0] JCC_C  = 2'b10;
    localparam logic [1:0] JCC_NC = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        OUT_WAIT,
        INCREMENT,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND
    } alu_op_t;

    function automatic logic jump_cond_met(input logic [1:0] cc, input logic z, input logic c);
        logic met;
        case (cc)
            JCC_Z:   met = z;
            JCC_NZ:  met = ~z;
            JCC_C:   met = c;
            default: met = ~c;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU for the accumulator core: pass/add/sub/and with carry
// (borrow on subtract) and zero outputs.
module accum_alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  alu_op_t               i_op,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_carry,
    output logic                  o_zero
);

    logic [DATA_WIDTH:0] w_wide;

    // One extra bit captures carry-out on add and borrow on subtract
    always_comb begin
        w_wide = {1'b0, i_b};
        case (i_op)
            ALU_ADD: w_wide = {1'b0, i_a} + {1'b0, i_b};
            ALU_SUB: w_wide = {1'b0, i_a} - {1'b0, i_b};
            ALU_AND: w_wide = {1'b0, i_a & i_b};
            default: w_wide = {1'b0, i_b};
        endcase
    end

    assign o_result = w_wide[DATA_WIDTH-1:0];
    assign o_carry  = w_wide[DATA_WIDTH];
    assign o_zero   = (w_wide[DATA_WIDTH-1:0] == '0);

endmodule

// File: rtl/accum_cpu_core.sv
// Parametrised accumulator CPU with external registered-read memory, a
// valid/ready output port and HALT. Macro CPU_SERIAL_OUT_EN adds SERIAL_OUT.
module accum_cpu_core
    import cpu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int ADDR_WIDTH  = 8,
    localparam int INSTR_WIDTH = 8 + ADDR_WIDTH
) (
    input  logic                   CLK,
    input  logic                   CLR,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDR,
    output logic                   MEM_WE,
    output logic [INSTR_WIDTH-1:0] MEM_WDATA,
    input  logic [INSTR_WIDTH-1:0] MEM_RDATA,
    output logic [DATA_WIDTH-1:0]  OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   HALTED
`ifdef CPU_SERIAL_OUT_EN
    ,
    output logic                   SERIAL_OUT
`endif
);

    localparam int EXT_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [INSTR_WIDTH-1:0]  r_ir;
    logic                    r_z;
    logic                    r_c;
    logic                    r_jump_taken;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;

    state_t                  w_state_next;
    logic [7:0]              w_opcode;
    logic [ADDR_WIDTH-1:0]   w_operand;
    logic [EXT_W-1:0]        w_operand_ext;
    logic [DATA_WIDTH-1:0]   w_imm;
    logic [DATA_WIDTH-1:0]   w_alu_b;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic                    w_alu_carry;
    logic                    w_alu_zero;
    alu_op_t                 w_alu_op;
    logic                    w_sel_input;
    logic                    w_acc_we;
    logic                    w_flags_we;
    logic                    w_take_jump;
    logic                    w_start_out;
    logic                    w_mem_we;
    logic                    w_handshake;
    logic                    w_unused_bits;

    assign w_opcode      = r_ir[INSTR_WIDTH-1 -: 8];
    assign w_operand     = r_ir[ADDR_WIDTH-1:0];
    assign w_operand_ext = EXT_W'(w_operand);
    assign w_imm         = w_operand_ext[DATA_WIDTH-1:0];
    assign w_alu_b       = w_sel_input ? MEM_RDATA[DATA_WIDTH-1:0] : w_imm;
    assign w_handshake   = (r_state == OUT_WAIT) && r_out_valid && OUT_READY;
    assign w_unused_bits = ^w_opcode[1:0];

    accum_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_a      (r_acc),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_alu_op     = ALU_PASS;
        w_sel_input  = 1'b0;
        w_acc_we     = 1'b0;
        w_flags_we   = 1'b0;
        w_take_jump  = 1'b0;
        w_start_out  = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            FETCH:  w_state_next = DECODE;
            DECODE: w_state_next = EXECUTE;
            EXECUTE: begin
                w_state_next = INCREMENT;
                case (w_opcode[7:4])
                    OP_LOAD: w_acc_we = 1'b1;
                    OP_ADD: begin
                        w_alu_op   = ALU_ADD;
                        w_acc_we   = 1'b1;
                        w_flags_we = 1'b1;
                    end
                    OP_AND: begin
                        w_alu_op   = ALU_AND;
                        w_acc_we   = 1'b1;
                        w_flags_we = 1'b1;
                    end
                    OP_SUB: begin
                        w_alu_op   = ALU_SUB;
                        w_acc_we   = 1'b1;
                        w_flags_we = 1'b1;
                    end
                    OP_INPUT: begin
                        w_sel_input = 1'b1;
                        w_acc_we    = 1'b1;
                    end
                    // All-ones operand targets the output port instead of memory
                    OP_OUTPUT: begin
                        if (w_operand == '1) begin
                            w_start_out  = 1'b1;
                            w_state_next = OUT_WAIT;
                        end else begin
                            w_mem_we = 1'b1;
                        end
                    end
                    OP_JUMP:  w_take_jump = 1'b1;
                    OP_JCOND: w_take_jump = jump_cond_met(w_opcode[3:2], r_z, r_c);
                    OP_HALT:  w_state_next = HALT;
                    default:  w_state_next = INCREMENT;
                endcase
            end
            OUT_WAIT: begin
                if (w_handshake) begin
                    w_state_next = INCREMENT;
                end
            end
            INCREMENT: w_state_next = FETCH;
            HALT:      w_state_next = HALT;
            default:   w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_pc         <= '0;
            r_acc        <= '0;
            r_ir         <= '0;
            r_z          <= 1'b0;
            r_c          <= 1'b0;
            r_jump_taken <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            if (r_state == DECODE) begin
                r_ir <= MEM_RDATA;
            end
            if (w_acc_we) begin
                r_acc <= w_alu_result;
            end
            if (w_flags_we) begin
                r_z <= w_alu_zero;
                r_c <= w_alu_carry;
            end
            if (w_take_jump) begin
                r_pc         <= w_operand;
                r_jump_taken <= 1'b1;
            end
            if (r_state == INCREMENT) begin
                if (!r_jump_taken) begin
                    r_pc <= r_pc + 1'b1;
                end
                r_jump_taken <= 1'b0;
            end
            if (w_start_out) begin
                r_out_data  <= r_acc;
                r_out_valid <= 1'b1;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef CPU_SERIAL_OUT_EN
    logic r_serial;

    // Legacy pin carries the inverted LSB of the last completed transfer
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_serial <= 1'b1;
        end else if (w_handshake) begin
            r_serial <= ~r_out_data[0];
        end
    end

    assign SERIAL_OUT = r_serial;
`endif

    always_comb begin
        case (r_state)
            DECODE:             MEM_ADDR = MEM_RDATA[ADDR_WIDTH-1:0];
            EXECUTE, OUT_WAIT:  MEM_ADDR = w_operand;
            default:            MEM_ADDR = r_pc;
        endcase
    end

    assign MEM_WE    = w_mem_we;
    assign MEM_WDATA = INSTR_WIDTH'(r_acc);
    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign HALTED    = (r_state == HALT);

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed self-checking bench for accum_cpu_core: small programs run from a
// registered-read memory model, results observed on the output port and HALT PC.
module tb_accum_cpu_core;

    logic        clk;
    logic        clr;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
`ifdef CPU_SERIAL_OUT_EN
    logic        serial_out;
`endif

    logic [15:0] mem [0:255];
    logic        ld_clear;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    int          xfer_cnt;
    logic [7:0]  xfer_data [0:63];
    int          we_cnt;
    logic [7:0]  we_addr [0:63];
    logic [15:0] we_data [0:63];

    int total;
    int bad;

    accum_cpu_core #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .CLK        (clk),
        .CLR        (clr),
        .MEM_ADDR   (mem_addr),
        .MEM_WE     (mem_we),
        .MEM_WDATA  (mem_wdata),
        .MEM_RDATA  (mem_rdata),
        .OUT_DATA   (out_data),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .HALTED     (halted)
`ifdef CPU_SERIAL_OUT_EN
        ,
        .SERIAL_OUT (serial_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: registered read, loadable from the bench while CLR is held
    always @(posedge clk) begin
        if (ld_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hF000;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (!clr && out_valid && out_ready) begin
            xfer_data[xfer_cnt[5:0]] <= out_data;
            xfer_cnt <= xfer_cnt + 1;
        end
        if (!clr && mem_we) begin
            we_addr[we_cnt[5:0]] <= mem_addr;
            we_data[we_cnt[5:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic begin_prog(input logic ready);
        @(negedge clk);
        clr       = 1'b1;
        out_ready = ready;
        ld_clear  = 1'b1;
        @(negedge clk);
        ld_clear  = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic release_clr();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        begin_prog(1'b1);
        #1;
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef CPU_SERIAL_OUT_EN
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_serial: got %b want 1", serial_out); end
`endif
        $display("test_reset: reset outputs checked");
    endtask

    task automatic test_default_program();
        int base;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h0005);
        load_word(8'h01, 16'h4003);
        load_word(8'h02, 16'hE0FF);
        load_word(8'h03, 16'hF000);
        base = xfer_cnt;
        release_clr();
        wait_halt(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL default_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 1) begin bad++; $display("FAIL default_xfer_cnt: got %0d want 1", xfer_cnt - base); end
        total++; if (xfer_data[base[5:0]] !== 8'h08) begin bad++; $display("FAIL default_out_data: got %h want 08", xfer_data[base[5:0]]); end
        total++; if (mem_addr !== 8'h03) begin bad++; $display("FAIL default_halt_pc: got %h want 03", mem_addr); end
        total++; if (out_valid !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL default_halt_quiet: got valid=%b we=%b want 0 0", out_valid, mem_we); end
        $display("test_default_program: transfers=%0d halt_pc=%h", xfer_cnt - base, mem_addr);
    endtask

    task automatic test_carry_jump();
        int base;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h00FF);
        load_word(8'h01, 16'h4001);
        load_word(8'h02, 16'h9810);
        load_word(8'h10, 16'hE0FF);
        load_word(8'h11, 16'h9020);
        load_word(8'h20, 16'h00AA);
        load_word(8'h21, 16'hE0FF);
        base = xfer_cnt;
        release_clr();
        wait_halt(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL carry_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 2) begin bad++; $display("FAIL carry_xfer_cnt: got %0d want 2", xfer_cnt - base); end
        total++; if (xfer_data[base[5:0]] !== 8'h00) begin bad++; $display("FAIL carry_acc_wrap: got %h want 00", xfer_data[base[5:0]]); end
        total++; if (xfer_data[5'(base + 1)] !== 8'hAA) begin bad++; $display("FAIL carry_jz_path: got %h want AA", xfer_data[5'(base + 1)]); end
        total++; if (mem_addr !== 8'h22) begin bad++; $display("FAIL carry_halt_pc: got %h want 22", mem_addr); end
        $display("test_carry_jump: transfers=%0d halt_pc=%h", xfer_cnt - base, mem_addr);
    endtask

    task automatic test_sub_path();
        int base;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h0000);
        load_word(8'h01, 16'h6001);
        load_word(8'h02, 16'h9C30);
        load_word(8'h03, 16'hE0FF);
        load_word(8'h04, 16'h9430);
        load_word(8'h30, 16'h0077);
        load_word(8'h31, 16'hE0FF);
        base = xfer_cnt;
        release_clr();
        wait_halt(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL sub_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 2) begin bad++; $display("FAIL sub_xfer_cnt: got %0d want 2", xfer_cnt - base); end
        total++; if (xfer_data[base[5:0]] !== 8'hFF) begin bad++; $display("FAIL sub_borrow_result: got %h want FF", xfer_data[base[5:0]]); end
        total++; if (xfer_data[5'(base + 1)] !== 8'h77) begin bad++; $display("FAIL sub_jnz_path: got %h want 77", xfer_data[5'(base + 1)]); end
        total++; if (mem_addr !== 8'h32) begin bad++; $display("FAIL sub_halt_pc: got %h want 32", mem_addr); end
        $display("test_sub_path: transfers=%0d halt_pc=%h", xfer_cnt - base, mem_addr);
    endtask

    task automatic test_and_flags();
        int base;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h00F0);
        load_word(8'h01, 16'h4020);
        load_word(8'h02, 16'h103C);
        load_word(8'h03, 16'hE0FF);
        load_word(8'h04, 16'h9810);
        load_word(8'h05, 16'h100F);
        load_word(8'h06, 16'h9020);
        load_word(8'h20, 16'hE0FF);
        base = xfer_cnt;
        release_clr();
        wait_halt(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL and_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 2) begin bad++; $display("FAIL and_xfer_cnt: got %0d want 2", xfer_cnt - base); end
        total++; if (xfer_data[base[5:0]] !== 8'h10) begin bad++; $display("FAIL and_result: got %h want 10", xfer_data[base[5:0]]); end
        total++; if (xfer_data[5'(base + 1)] !== 8'h00) begin bad++; $display("FAIL and_zero_result: got %h want 00", xfer_data[5'(base + 1)]); end
        total++; if (mem_addr !== 8'h21) begin bad++; $display("FAIL and_halt_pc: got %h want 21", mem_addr); end
        $display("test_and_flags: transfers=%0d halt_pc=%h", xfer_cnt - base, mem_addr);
    endtask

    task automatic test_mem_rw();
        int base;
        int wbase;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h005A);
        load_word(8'h01, 16'hE040);
        load_word(8'h02, 16'h0000);
        load_word(8'h03, 16'hA040);
        load_word(8'h04, 16'hE0FF);
        base  = xfer_cnt;
        wbase = we_cnt;
        release_clr();
        wait_halt(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL memrw_halt: got halted=%b want 1", halted); end
        total++; if (we_cnt - wbase != 1) begin bad++; $display("FAIL memrw_we_cycles: got %0d want 1", we_cnt - wbase); end
        total++; if (we_addr[wbase[5:0]] !== 8'h40) begin bad++; $display("FAIL memrw_we_addr: got %h want 40", we_addr[wbase[5:0]]); end
        total++; if (we_data[wbase[5:0]] !== 16'h005A) begin bad++; $display("FAIL memrw_we_data: got %h want 005A", we_data[wbase[5:0]]); end
        total++; if (mem[8'h40] !== 16'h005A) begin bad++; $display("FAIL memrw_mem_word: got %h want 005A", mem[8'h40]); end
        total++; if (xfer_data[base[5:0]] !== 8'h5A || xfer_cnt - base != 1) begin bad++; $display("FAIL memrw_input_readback: got %h (n=%0d) want 5A (n=1)", xfer_data[base[5:0]], xfer_cnt - base); end
        total++; if (mem_addr !== 8'h05) begin bad++; $display("FAIL memrw_halt_pc: got %h want 05", mem_addr); end
`ifdef CPU_SERIAL_OUT_EN
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL memrw_serial: got %b want 1", serial_out); end
`endif
        $display("test_mem_rw: writes=%0d transfers=%0d", we_cnt - wbase, xfer_cnt - base);
    endtask

    task automatic test_backpressure();
        int base;
        int wbase;
        int cnt;
        bit stable;
        bit ok;
        begin_prog(1'b0);
        load_word(8'h00, 16'h0033);
        load_word(8'h01, 16'hE0FF);
        base  = xfer_cnt;
        wbase = we_cnt;
        release_clr();
        cnt    = 0;
        stable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (out_data !== 8'h33 || mem_addr !== 8'hFF) stable = 1'b0;
                if (cnt == 6) out_ready = 1'b1;
            end else if (cnt > 0) begin
                break;
            end
        end
        total++; if (cnt != 6) begin bad++; $display("FAIL bp_valid_cycles: got %0d want 6", cnt); end
        total++; if (!stable) begin bad++; $display("FAIL bp_data_stable: got unstable want 33 held at addr FF"); end
        total++; if (we_cnt != wbase) begin bad++; $display("FAIL bp_no_mem_write: got %0d writes want 0", we_cnt - wbase); end
        wait_halt(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 1 || xfer_data[base[5:0]] !== 8'h33) begin bad++; $display("FAIL bp_xfer: got %h (n=%0d) want 33 (n=1)", xfer_data[base[5:0]], xfer_cnt - base); end
        total++; if (mem_addr !== 8'h02) begin bad++; $display("FAIL bp_halt_pc: got %h want 02", mem_addr); end
`ifdef CPU_SERIAL_OUT_EN
        total++; if (serial_out !== 1'b0) begin bad++; $display("FAIL bp_serial: got %b want 0", serial_out); end
`endif
        $display("test_backpressure: valid_cycles=%0d halt_pc=%h", cnt, mem_addr);
    endtask

    task automatic test_pc_wrap();
        int base;
        bit ok;
        begin_prog(1'b1);
        load_word(8'h00, 16'h9410);
        load_word(8'h01, 16'h00C3);
        load_word(8'h02, 16'hE0FF);
        load_word(8'h10, 16'h0001);
        load_word(8'h11, 16'h6001);
        load_word(8'h12, 16'h80FF);
        load_word(8'hFF, 16'h2000);
        base = xfer_cnt;
        release_clr();
        wait_halt(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_halt: got halted=%b want 1", halted); end
        total++; if (xfer_cnt - base != 1 || xfer_data[base[5:0]] !== 8'hC3) begin bad++; $display("FAIL wrap_xfer: got %h (n=%0d) want C3 (n=1)", xfer_data[base[5:0]], xfer_cnt - base); end
        total++; if (mem_addr !== 8'h03) begin bad++; $display("FAIL wrap_halt_pc: got %h want 03", mem_addr); end
        $display("test_pc_wrap: transfers=%0d halt_pc=%h", xfer_cnt - base, mem_addr);
    endtask

    task automatic test_clr_in_out_wait();
        int base;
        bit seen;
        bit ok;
        begin_prog(1'b0);
        load_word(8'h00, 16'h0077);
        load_word(8'h01, 16'hE0FF);
        release_clr();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL clr_reach_wait: got valid=%b want 1", out_valid); end
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_async_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL clr_async_data: got %h want 00", out_data); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL clr_async_pc: got %h want 00", mem_addr); end
`ifdef CPU_SERIAL_OUT_EN
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL clr_serial: got %b want 1", serial_out); end
`endif
        @(negedge clk);
        out_ready = 1'b1;
        base = xfer_cnt;
        clr = 1'b0;
        wait_halt(100, ok);
        total++; if (!ok || xfer_cnt - base != 1 || xfer_data[base[5:0]] !== 8'h77) begin bad++; $display("FAIL clr_restart: got halted=%b data=%h n=%0d want 1 77 1", halted, xfer_data[base[5:0]], xfer_cnt - base); end
        total++; if (mem_addr !== 8'h02) begin bad++; $display("FAIL clr_restart_pc: got %h want 02", mem_addr); end
        $display("test_clr_in_out_wait: restart transfers=%0d", xfer_cnt - base);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        xfer_cnt  = 0;
        we_cnt    = 0;
        clr       = 1'b1;
        out_ready = 1'b1;
        ld_clear  = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 8'h00;
        ld_data   = 16'h0000;
        test_reset();
        test_default_program();
        test_carry_jump();
        test_sub_path();
        test_and_flags();
        test_mem_rw();
        test_backpressure();
        test_pc_wrap();
        test_clr_in_out_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
